alu_seq: RTL
============

# alu_seq

Parametrised, handshaked ALU for the combinational datapath family. It generalises the fixed 16-bit, purely combinational ALU to any `WIDTH`. It adds registered operands and results, a carry/borrow flag, and an iterative shift-add multiplier that runs for several cycles. Upstream control logic drives it with a start/done handshake.

## Interface
- `WIDTH`, default 16: operand and result width. Legal range is `WIDTH` ≥ 4.
- `SHW`, localparam, `$clog2(WIDTH)`: number of shift-amount bits taken from `b`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request an operation. Sampled only in IDLE.
- `a` input, `WIDTH` bits: operand A. Latched when `start` is accepted.
- `b` input, `WIDTH` bits: operand B. Latched when `start` is accepted.
- `cin` input, 1 bit: carry/borrow in. Latched when `start` is accepted.
- `func` input, 3 bits: operation select. Latched when `start` is accepted.
- `w` output, `WIDTH` bits: registered result.
- `zero` output, 1 bit: `w == 0`, registered together with `w`.
- `neg` output, 1 bit: `w[WIDTH-1]`, registered together with `w`.
- `cout` output, 1 bit: carry, borrow or overflow flag, registered together with `w`.
- `busy` output, 1 bit: an operation is in flight.
- `done` output, 1 bit: one-cycle pulse. `w` and the flags are updated in the same cycle.

## Operation
- The clock is `clk`. Reset is `rst`, asynchronous and active-high.
- `func` encoding and results; all arithmetic is modulo 2^`WIDTH`:
  - 0 ADD: `w = a + b + cin`. `cout` is bit `WIDTH` of the sum.
  - 1 SUB: `w = a - b - cin`. `cout` = 1 when the subtraction borrows, i.e. a < b + cin, unsigned.
  - 2 AND: `w = a & b`. `cout` = 0.
  - 3 OR: `w = a | b`. `cout` = 0.
  - 4 XOR: `w = a ^ b`. `cout` = 0.
  - 5 NOT: `w = ~a`. `cout` = 0.
  - 6 SHL: `w = a << b[SHW-1:0]`. `cout` is the last bit shifted out, or 0 when the shift amount is 0.
  - 7 MUL: `w` = low `WIDTH` bits of `a*b`, unsigned, computed by iterative shift-add. `cout` = 1 when the high half of the full product is non-zero.
- State machine: IDLE, EXEC, MUL.
  - IDLE + `start`: latch `a`, `b`, `cin`, `func`. Go to MUL when `func == 7`, otherwise go to EXEC.
  - EXEC: compute the result, register `w` and the flags, pulse `done`, return to IDLE.
  - MUL: one multiplier bit per cycle, LSB first, with an internal counter from 0 to `WIDTH-1`. On the final step, register `w` and the flags, pulse `done`, return to IDLE.
- Accumulator: the internal product register is `2*WIDTH` bits wide, so no intermediate overflow is lost.
- `start` while `busy` is ignored. It is neither queued nor latched, and the in-flight operation is unaffected.
- Input changes after acceptance have no effect on the in-flight operation.
- `w`, `zero`, `neg` and `cout` hold their last values until the next `done`.
- Reset values: `w` = 0, `zero` = 1, `neg` = 0, `cout` = 0, `busy` = 0, `done` = 0, state = IDLE, multiplier counter and accumulator = 0.
- `rst` during EXEC or MUL aborts the operation immediately. Outputs go to their reset values, and no `done` is produced for the aborted operation.

## Timing
- Let edge E0 be the edge that accepts `start`.
- `busy` = 1 after E0 and stays high until the completing edge. It is 0 in the cycle where `done` = 1.
- Non-MUL ops: `done`, `w` and the flags are valid after edge E0+1. Latency is 1 cycle.
- MUL: `done`, `w` and the flags are valid after edge E0+`WIDTH`. Latency is `WIDTH` cycles; for `WIDTH` = 16 this is 16 cycles.
- `done` is high for exactly one cycle.
- Back-to-back operation: `start` held high in the `done` cycle is accepted at the next edge. Sustained throughput is 1 op per 2 cycles for single-cycle ops.
- `zero` and `neg` are derived from the new `w` value, never from the previous one.

## Test plan
- Reset, then ADD with a=0xFFFF, b=0x0001, cin=0 (`WIDTH` = 16) → one cycle later: `w` = 0x0000, `zero` = 1, `neg` = 0, `cout` = 1, and `done` pulses for 1 cycle.
- SUB with a=0x0003, b=0x0005, cin=0 → `w` = 0xFFFE, `neg` = 1, `zero` = 0, `cout` = 1. Then SHL with a=0x0001, b=0x000F → `w` = 0x8000, `neg` = 1, `cout` = 0.
- MUL with a=0x0012, b=0x0034 → `busy` high for 16 cycles, then `w` = 0x03A8, `cout` = 0, and exactly one `done`. MUL with a=0x0100, b=0x0100 → `w` = 0x0000, `zero` = 1, `cout` = 1.
- During a MUL, pulse `start` with func=0, a=1, b=1 at cycle 5 → ignored. The MUL result is unchanged and only one `done` occurs.
- Assert `rst` at cycle 8 of a MUL → `busy`, `done`, `w` and `cout` go to 0 and `zero` goes to 1 immediately. A subsequent AND with a=0xF0F0, b=0xFF00 → `w` = 0xF000 after 1 cycle.
- Random regression: run 1000 random {a, b, cin, func} operations, with `start` held high back-to-back, at `WIDTH` = 8, 16 and 32. Compare every `done` against a behavioural reference model on `w`, `zero`, `neg` and `cout`.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: parametrised ALU with registered operands and results, a
// carry/borrow/overflow flag, and an iterative shift-add multiplier.
// Upstream logic drives it with a start/done handshake.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] w,
  output logic             zero,
  output logic             neg,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    F_ADD = 3'd0,
    F_SUB = 3'd1,
    F_AND = 3'd2,
    F_OR  = 3'd3,
    F_XOR = 3'd4,
    F_NOT = 3'd5,
    F_SHL = 3'd6,
    F_MUL = 3'd7
  } func_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               cin_r;
  func_t              func_r;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [SHW-1:0]     cnt;
  logic               last_step;
  logic [WIDTH-1:0]   alu_w;
  logic               alu_c;
  logic [WIDTH:0]     ext;

  assign busy      = (state != IDLE);
  assign last_step = (cnt == SHW'(WIDTH - 1));

  // Next-state logic for the IDLE / EXEC / MUL controller.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (func_t'(func) == F_MUL) ? MUL : EXEC;
      EXEC:    state_nxt = IDLE;
      MUL:     if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle operations on the latched operands; ext carries bit WIDTH
  // so carry, borrow and the last shifted-out bit all fall out of one add/shift.
  always_comb begin
    ext   = '0;
    alu_w = '0;
    alu_c = 1'b0;
    case (func_r)
      F_ADD: begin
        ext   = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
        alu_w = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
      end
      F_SUB: begin
        // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow: set exactly
        // when a < b + cin, including b = all-ones with cin = 1.
        ext   = {1'b0, a_r} - {1'b0, b_r} - {{WIDTH{1'b0}}, cin_r};
        alu_w = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
      end
      F_AND: alu_w = a_r & b_r;
      F_OR:  alu_w = a_r | b_r;
      F_XOR: alu_w = a_r ^ b_r;
      F_NOT: alu_w = ~a_r;
      F_SHL: begin
        // A shift of zero leaves ext[WIDTH] clear, which gives cout = 0.
        ext   = {1'b0, a_r} << b_r[SHW-1:0];
        alu_w = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
      end
      default: alu_w = '0;
    endcase
  end

  // One shift-add step: b_r is shifted right each cycle, so bit 0 is the
  // current multiplier bit; mcand is the multiplicand aligned to that bit.
  always_comb begin
    acc_nxt = acc + (b_r[0] ? mcand : '0);
  end

  // State, operand latches, multiplier datapath and registered results.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      cin_r  <= 1'b0;
      func_r <= F_ADD;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      w      <= '0;
      zero   <= 1'b1;
      neg    <= 1'b0;
      cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            cin_r  <= cin;
            func_r <= func_t'(func);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            cnt    <= '0;
          end
        end
        EXEC: begin
          w    <= alu_w;
          zero <= (alu_w == '0);
          neg  <= alu_w[WIDTH-1];
          cout <= alu_c;
          done <= 1'b1;
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          b_r   <= b_r >> 1;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            w    <= acc_nxt[WIDTH-1:0];
            zero <= (acc_nxt[WIDTH-1:0] == '0);
            neg  <= acc_nxt[WIDTH-1];
            cout <= |acc_nxt[2*WIDTH-1:WIDTH];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
